pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg_if : valid/ready handshake bundle between pipeline stages
// Revision 1.0
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg : CHANNELS x WIDTH inter-stage register, 2-entry skid, flush
// Optional stall counter enabled by PIPE_STAGE_PERF_CNT_EN.  Revision 1.0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic         ref_clk,
  input  wire logic         rst,
  pipe_stage_reg_if.slave   bus
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main [CHANNELS];
  logic [WIDTH-1:0] r_skid [CHANNELS];
  logic [WIDTH-1:0] w_in_word [CHANNELS];

  logic w_accept;
  logic w_drain;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_drain  = r_out_valid && bus.out_ready;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      assign w_in_word[k]                  = bus.in_data[k*WIDTH +: WIDTH];
      assign bus.out_data[k*WIDTH +: WIDTH] = r_main[k];
    end
  endgenerate

  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;

  // Reset and flush leave identical state; only the stall counter tells them apart.
  always_ff @(posedge ref_clk) begin
    if (rst || bus.flush) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        r_main[k] <= '0;
        r_skid[k] <= '0;
      end
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_in_word;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            r_main <= w_in_word;
          end else if (w_accept) begin
            r_skid     <= w_in_word;
            r_in_ready <= 1'b0;
            r_state    <= S_FULL;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  logic [CNT_WIDTH-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg : scoreboard bench for pipe_stage_reg (2x32 and 4x8)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(32), .CHANNELS(2)) bus0 ();
  pipe_stage_reg_if #(.WIDTH(8),  .CHANNELS(4)) bus1 ();

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [3:0] stall_cnt0;
  logic [3:0] stall_cnt1;
`endif

  pipe_stage_reg #(.WIDTH(32), .CHANNELS(2), .CNT_WIDTH(4)) dut0 (
    .ref_clk   (clk),
    .rst       (rst),
    .bus       (bus0)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt0)
`endif
  );

  pipe_stage_reg #(.WIDTH(8), .CHANNELS(4), .CNT_WIDTH(4)) dut1 (
    .ref_clk   (clk),
    .rst       (rst),
    .bus       (bus1)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] ch0, input logic [31:0] ch1);
    bus0.in_valid = 1'b1;
    bus0.in_data  = {ch1, ch0};
    tick();
  endtask

  // Accepts are recorded and outputs retired mid-cycle, when inputs are stable.
  always @(negedge clk) begin
    if (rst || bus0.flush) begin
      sb.delete();
    end else begin
      if (bus0.out_valid && bus0.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_out", {32'd0, bus0.out_data[31:0]}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check_eq("sb_data", bus0.out_data, sb.pop_front());
        end
      end
      if (bus0.in_valid && bus0.in_ready) sb.push_back(bus0.in_data);
    end
  end

  initial begin
    rst            = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = {32'h0, 32'h7FF};
    bus0.out_ready = 1'b0;
    bus0.flush     = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b0;
    bus1.flush     = 1'b0;

    repeat (2) tick();
    rst           = 1'b0;
    bus0.in_valid = 1'b0;
    check_eq("rst_out_valid", bus0.out_valid, 0);
    check_eq("rst_out_data",  bus0.out_data,  0);
    check_eq("rst_in_ready",  bus0.in_ready,  1);
    check_eq("rst_out_data1", bus1.out_data,  0);

    // Streaming at full rate
    bus0.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push0(i, i + 100);
      check_eq("stream_valid", bus0.out_valid, 1);
      check_eq("stream_data",  bus0.out_data, {32'(i + 100), 32'(i)});
      check_eq("stream_ready", bus0.in_ready, 1);
    end
    bus0.in_valid = 1'b0;
    tick();
    check_eq("stream_empty", bus0.out_valid, 0);

    // Back-pressure into the skid
    bus0.out_ready = 1'b0;
    push0(32'hA, 32'hA0);
    check_eq("bp_a_out",   bus0.out_data, {32'hA0, 32'hA});
    check_eq("bp_a_ready", bus0.in_ready, 1);
    push0(32'hB, 32'hB0);
    check_eq("bp_b_hold",  bus0.out_data, {32'hA0, 32'hA});
    check_eq("bp_b_ready", bus0.in_ready, 0);
    push0(32'hC, 32'hC0);
    check_eq("bp_c_hold",  bus0.out_data, {32'hA0, 32'hA});
    check_eq("bp_c_valid", bus0.out_valid, 1);
    check_eq("bp_c_ready", bus0.in_ready, 0);
    bus0.out_ready = 1'b1;
    tick();
    check_eq("bp_drain_b",     bus0.out_data, {32'hB0, 32'hB});
    check_eq("bp_ready_back",  bus0.in_ready, 1);
    tick();
    check_eq("bp_drain_c",     bus0.out_data, {32'hC0, 32'hC});
    bus0.in_valid = 1'b0;
    tick();
    check_eq("bp_empty", bus0.out_valid, 0);

    // Flush while FULL with a concurrent request
    bus0.out_ready = 1'b0;
    push0(32'h10, 32'h0);
    push0(32'h11, 32'h0);
    check_eq("fl_full_ready", bus0.in_ready, 0);
    bus0.in_data = {32'h0, 32'h12};
    bus0.flush   = 1'b1;
    tick();
    bus0.flush    = 1'b0;
    bus0.in_valid = 1'b0;
    check_eq("fl_out_valid", bus0.out_valid, 0);
    check_eq("fl_out_data",  bus0.out_data,  0);
    check_eq("fl_in_ready",  bus0.in_ready,  1);
    bus0.out_ready = 1'b1;
    repeat (3) begin
      tick();
      check_eq("fl_no_ghost", bus0.out_valid, 0);
    end

    // Flush in ONE discards an accept in the same cycle
    bus0.out_ready = 1'b0;
    push0(32'h20, 32'h0);
    bus0.in_data = {32'h0, 32'h21};
    bus0.flush   = 1'b1;
    tick();
    bus0.flush    = 1'b0;
    bus0.in_valid = 1'b0;
    check_eq("fl1_out_valid", bus0.out_valid, 0);
    check_eq("fl1_in_ready",  bus0.in_ready,  1);
    tick();
    check_eq("fl1_dropped", bus0.out_valid, 0);

    // Reset mid-transfer
    push0(32'h30, 32'h0);
    push0(32'h31, 32'h0);
    bus0.in_data = {32'h0, 32'h32};
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus0.in_valid = 1'b0;
    check_eq("mrst_out_valid", bus0.out_valid, 0);
    check_eq("mrst_out_data",  bus0.out_data,  0);
    check_eq("mrst_in_ready",  bus0.in_ready,  1);

`ifdef PIPE_STAGE_PERF_CNT_EN
    check_eq("cnt_after_rst", stall_cnt0, 0);
    push0(32'h40, 32'h0);
    bus0.in_valid = 1'b0;
    check_eq("cnt_start", stall_cnt0, 0);
    repeat (3) tick();
    check_eq("cnt_three", stall_cnt0, 3);
    repeat (17) tick();
    check_eq("cnt_sat", stall_cnt0, 15);
    bus0.flush = 1'b1;
    tick();
    bus0.flush = 1'b0;
    tick();
    check_eq("cnt_flush_keeps", stall_cnt0, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("cnt_rst_clears", stall_cnt0, 0);
`endif

    // Channel packing on the 4x8 instance
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 32'h0403_0201;
    bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check_eq("pack_word", bus1.out_data, 64'h0403_0201);
    check_eq("pack_ch2",  bus1.out_data[2*8 +: 8], 8'h03);
    tick();
    check_eq("pack_empty", bus1.out_valid, 0);

    bus0.out_ready = 1'b1;
    repeat (3) tick();
    check_eq("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
